mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the word-address width (depth = 2**ADDR_W words).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the data word width, matching the CPU accumulator.
REQ-003 The block SHALL have parameter WAIT_CYC, default 2, meaning the wait states inserted before each response (legal range 0..15).
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  1  request strobe from the CPU (initiator), sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read, qualified by req.
REQ-008 addr  input  ADDR_W  word address, qualified by req.
REQ-009 wdata  input  DATA_W  write data, qualified by req and we.
REQ-010 rdata  output  DATA_W  read data, valid only while ack=1.
REQ-011 ack  output  1  one-cycle response pulse completing the transaction.
REQ-012 busy  output  1  high from the cycle after an accepted req until the cycle after ack.
REQ-013 ovf  output  1  sticky flag; set when req=1 is seen while busy=1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, the block SHALL latch we, addr and wdata, then go to WAIT if WAIT_CYC>0, else to RESP.
REQ-016 In WAIT, a 4-bit counter loaded with WAIT_CYC-1 SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-017 In RESP, ack SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE.
REQ-018 Latency from the edge sampling req to the edge where ack is first seen high SHALL be WAIT_CYC+1 cycles.
REQ-019 A write SHALL update the array at the latched address on the RESP edge; rdata SHALL be zero during a write ack.
REQ-020 A read SHALL present the array word at the latched address on rdata in the RESP cycle, registered; rdata SHALL be 0 whenever ack=0.
REQ-021 A req arriving in the RESP cycle SHALL be ignored and SHALL set ovf; back-to-back transactions need req in IDLE.
REQ-022 req while busy SHALL NOT alter the latched request, the counter or the array, and SHALL set ovf (sticky until rst).
REQ-023 A read after a write to the same address SHALL return the written value; a read of a never-written word SHALL return unspecified data (no X on ack/busy).
REQ-024 Address arithmetic SHALL NOT wrap or offset: addr selects exactly one word; there is no out-of-range case.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, counter 0, ack=0, busy=0, ovf=0 and rdata=0, and clear the latched request.
REQ-026 Reset mid-transaction SHALL abort it: no ack, and a pending write SHALL NOT reach the array.
REQ-027 Array contents SHALL NOT be reset.

Structure
REQ-028 Package mem_responder_pkg SHALL hold the state enum (IDLE, WAIT, RESP), the default widths and the WAIT_CYC limit constant.
REQ-029 The storage SHALL be a sub-module mem_responder_ram: single-port, synchronous write, registered read, DATA_W x 2**ADDR_W.
REQ-030 The FSM, counter, request latch and ovf logic SHALL live in mem_responder.

Verification
REQ-031 rst high for 2 cycles, then low; check that ack=0, busy=0, ovf=0, rdata=0 throughout and after.
REQ-032 With WAIT_CYC=2, write 0x1234 to addr 0x05 then read 0x05. Check that ack comes 3 cycles after each req, and the read ack has rdata=0x1234.
REQ-033 With WAIT_CYC=0, write 0xFFFF to 0xFF, then read 0x00 after writing 0x0001 there. Check each ack 1 cycle after req, with read data 0x0001.
REQ-034 Pulse req during WAIT with addr 0x10 and we=1. Check that ovf=1, the original transaction completes unchanged, and a later read of 0x10 does not return that wdata.
REQ-035 Assert rst during WAIT of a write of 0xABCD to 0x20. Check that there is no ack and all outputs are 0; a read of 0x20 after a prior write of 0x0042 returns 0x0042.
REQ-036 Issue 8 back-to-back read/write pairs with random data. Check that every ack is one cycle wide, busy drops the cycle after ack, and all reads match the scoreboard.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the memory responder slice.
package mem_responder_pkg;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefWaitCyc = 2;
  localparam int unsigned MaxWaitCyc = 15;
  localparam int unsigned CntW       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port storage: synchronous write, registered read, contents never reset.
module mem_responder_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: latches one CPU request, waits WAIT_CYC cycles, then acks once.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned WAIT_CYC = DefWaitCyc
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned WaitCyc = (WAIT_CYC > MaxWaitCyc) ? MaxWaitCyc : WAIT_CYC;
  localparam logic [CntW-1:0] CntLoad = (WaitCyc > 0) ? CntW'(WaitCyc - 1) : '0;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ovf_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (req && busy) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WaitCyc > 0) begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The RAM read must launch on the edge entering StResp; with no wait states that
  // edge is the one sampling req, so the port follows the live address while idle.
  always_comb begin
    ack      = (state_q == StResp);
    busy     = (state_q != StIdle);
    ovf      = ovf_q;
    ram_we   = ack && we_q;
    ram_addr = (state_q == StIdle) ? addr : addr_q;
    rdata    = (ack && !we_q) ? ram_rdata : '0;
  end

  mem_responder_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
